// File: rtl/snes_controller_emulator_if.sv
// SNES pad serial link: host drives latch/pulse, the pad answers on data.
interface snes_controller_emulator_if;
    logic snes_latch;
    logic snes_pulse;
    logic snes_data;

    modport master (output snes_latch, output snes_pulse, input snes_data);
    modport slave  (input snes_latch, input snes_pulse, output snes_data);
endinterface

// File: rtl/snes_controller_emulator.sv
// Impersonates one SNES pad: captures a 12-bit button word on latch and
// shifts it out active-low, one bit per host pulse rise.
module snes_controller_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int FRAME_BITS     = 16,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic                             sys_clk,
    input  logic                             sys_reset_n,
    input  logic                             enable,
    input  logic [11:0]                      buttons,
    snes_controller_emulator_if.slave        snes,
    output logic                             frame_done,
    output logic [7:0]                       poll_count
);
    localparam int BTN_BITS = 12;
    localparam int K_W      = $clog2(FRAME_BITS);
    localparam int T_W      = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_SHIFT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_latch_sync, r_pulse_sync;
    logic                    r_latch_prev, r_pulse_prev;
    logic [BTN_BITS-1:0]     r_shreg, w_shreg_nxt;
    logic [K_W-1:0]          r_k, w_k_nxt;
    logic [T_W-1:0]          r_tmo, w_tmo_nxt;
    logic                    r_data, w_data_nxt;
    logic                    r_done, w_done_nxt;
    logic [7:0]              r_poll, w_poll_nxt;

    logic w_latch, w_latch_rise, w_pulse_rise, w_event, w_tmo_hit, w_abort;

    assign w_latch      = r_latch_sync[SYNC_STAGES-1];
    assign w_latch_rise = w_latch & ~r_latch_prev;
    assign w_pulse_rise = r_pulse_sync[SYNC_STAGES-1] & ~r_pulse_prev;
    assign w_event      = w_latch_rise | w_pulse_rise;
    assign w_tmo_hit    = (r_tmo == T_W'(TIMEOUT_CYCLES - 1));
    // Disable, or a stalled frame, drops straight back to IDLE without frame_done.
    assign w_abort      = !enable || (r_state != ST_IDLE && w_tmo_hit && !w_event);

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_latch_sync <= '0;
            r_pulse_sync <= '0;
            r_latch_prev <= 1'b0;
            r_pulse_prev <= 1'b0;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], snes.snes_latch};
            r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], snes.snes_pulse};
            r_latch_prev <= w_latch;
            r_pulse_prev <= r_pulse_sync[SYNC_STAGES-1];
        end
    end

    // NOTE: flops use <= so every register samples the same pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_k     <= '0;
            r_tmo   <= '0;
            r_data  <= 1'b1;
            r_done  <= 1'b0;
            r_poll  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_k     <= w_k_nxt;
            r_tmo   <= w_tmo_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_poll  <= w_poll_nxt;
        end
    end

    always_comb begin
        // NOTE: every next value gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_k_nxt     = r_k;
        w_tmo_nxt   = r_tmo;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_poll_nxt  = r_poll;

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_data_nxt  = 1'b1;
            w_tmo_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_data_nxt = 1'b1;
                    w_tmo_nxt  = '0;
                    if (w_latch_rise) begin
                        w_state_nxt = ST_LATCH;
                        w_shreg_nxt = buttons;
                        w_k_nxt     = '0;
                        w_data_nxt  = ~buttons[BTN_BITS-1];
                    end
                end
                ST_LATCH: begin
                    w_tmo_nxt = w_event ? '0 : r_tmo + 1'b1;
                    if (w_latch) begin
                        w_shreg_nxt = buttons;
                        w_k_nxt     = '0;
                        w_data_nxt  = ~buttons[BTN_BITS-1];
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_tmo_nxt = w_event ? '0 : r_tmo + 1'b1;
                    if (w_latch_rise) begin
                        w_state_nxt = ST_LATCH;
                        w_shreg_nxt = buttons;
                        w_k_nxt     = '0;
                        w_data_nxt  = ~buttons[BTN_BITS-1];
                    end else if (w_pulse_rise) begin
                        if (r_k == K_W'(FRAME_BITS - 1)) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                            w_poll_nxt  = r_poll + 8'd1;
                            w_data_nxt  = 1'b1;
                            w_k_nxt     = '0;
                        end else begin
                            w_shreg_nxt = {r_shreg[BTN_BITS-2:0], 1'b0};
                            w_k_nxt     = r_k + 1'b1;
                            // Bits past the button word are always sent released.
                            w_data_nxt  = (r_k < K_W'(BTN_BITS - 1)) ? ~r_shreg[BTN_BITS-2] : 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign snes.snes_data = r_data;
    assign frame_done     = r_done;
    assign poll_count     = r_poll;
endmodule

// File: tb/tb_snes_controller_emulator.sv
// Directed bench for the SNES pad emulator: a frame-level model predicts the
// serial data and poll count; literal sequences pin the model.
module tb_snes_controller_emulator;
    localparam int S  = 2;
    localparam int FB = 16;
    localparam int TO = 1000;
    localparam int HP = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] buttons;
    logic        frame_done;
    logic [7:0]  poll_count;

    snes_controller_emulator_if bus ();

    snes_controller_emulator #(
        .SYNC_STAGES   (S),
        .FRAME_BITS    (FB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk    (clk),
        .sys_reset_n(rst_n),
        .enable     (enable),
        .buttons    (buttons),
        .snes       (bus),
        .frame_done (frame_done),
        .poll_count (poll_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 latched (tracks live buttons), 2 shifting bit m_k of m_word.
    int          m_mode = 0;
    int          m_k = 0;
    logic [11:0] m_word = '0;
    int          m_polls = 0;
    int          m_done = 0;
    int          obs_done = 0;
    int          mask = 0;
    int          quiet = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_data();
        if (m_mode == 1) return ~buttons[11];
        if (m_mode == 2 && m_k < 12) return ~m_word[11 - m_k];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_k     = 0;
        m_word  = '0;
        m_polls = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic set_latch(input logic v);
        if (v && !bus.snes_latch) begin
            quiet = 0;
            if (enable) begin
                m_mode = 1;
                m_k    = 0;
            end
        end else if (!v && bus.snes_latch && m_mode == 1) begin
            m_word = buttons;
            m_mode = 2;
        end
        bus.snes_latch = v;
        mask = S + 3;
    endtask

    task automatic set_pulse(input logic v);
        if (v && !bus.snes_pulse) begin
            quiet = 0;
            if (m_mode == 2) begin
                m_k++;
                if (m_k == FB) begin
                    m_mode  = 0;
                    m_polls = (m_polls + 1) % 256;
                    m_done++;
                end
            end
        end
        bus.snes_pulse = v;
        mask = S + 3;
    endtask

    task automatic set_enable(input logic v);
        enable = v;
        if (!v) m_mode = 0;
        mask = 3;
    endtask

    task automatic set_buttons(input logic [11:0] b);
        buttons = b;
        mask = 3;
    endtask

    task automatic run_pulses(input int n, output logic [15:0] seq);
        seq = '1;
        for (int k = 0; k < n; k++) begin
            seq[15 - k] = bus.snes_data;
            set_pulse(1'b1);
            tick(HP);
            set_pulse(1'b0);
            tick(HP);
        end
    endtask

    task automatic latch_pulse();
        set_latch(1'b1);
        tick(HP);
        set_latch(1'b0);
        tick(HP);
    endtask

    task automatic do_frame(input logic [11:0] b, output logic [15:0] seq);
        set_buttons(b);
        tick(HP);
        latch_pulse();
        run_pulses(FB, seq);
    endtask

    // Single compare process: every settled cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) obs_done++;
            quiet++;
            if (m_mode != 0 && quiet > TO + S + 6) m_mode = 0;
            if (mask > 0) mask--;
            else if (!(m_mode != 0 && quiet >= TO - 5)) begin
                check("snes_data", bus.snes_data, exp_data());
                check("poll_count", poll_count, m_polls[7:0]);
                check("frame_count", obs_done, m_done);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no end want end");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq;
        int          base;

        rst_n = 1'b0;
        enable = 1'b1;
        buttons = '0;
        bus.snes_latch = 1'b0;
        bus.snes_pulse = 1'b0;
        model_reset();
        tick(3);
        check("reset_data", bus.snes_data, 1);
        check("reset_done", frame_done, 0);
        check("reset_poll", poll_count, 0);
        rst_n = 1'b1;
        mask = 2;
        tick(HP);

        // 1: B and R pressed.
        do_frame(12'h801, seq);
        check("t1_seq", seq, 16'h7FEF);
        check("t1_poll", poll_count, 1);
        check("t1_done", obs_done, 1);

        // 2: live tracking while latched, word frozen after latch falls.
        set_buttons(12'h000);
        tick(HP);
        set_latch(1'b1);
        tick(HP);
        set_buttons(12'hFFF);
        tick(3);
        check("t2_live_pressed", bus.snes_data, 0);
        set_buttons(12'h000);
        tick(3);
        check("t2_live_released", bus.snes_data, 1);
        set_buttons(12'hFFF);
        tick(HP);
        set_latch(1'b0);
        tick(HP);
        set_buttons(12'h000);
        tick(HP);
        run_pulses(FB, seq);
        check("t2_seq", seq, 16'h000F);
        check("t2_poll", poll_count, 2);

        // 3: latch during shift aborts; restarted frame completes.
        set_buttons(12'hFFF);
        tick(HP);
        latch_pulse();
        run_pulses(5, seq);
        check("t3_abort_done", obs_done, 2);
        do_frame(12'h555, seq);
        check("t3_seq", seq, 16'hAAAF);
        check("t3_poll", poll_count, 3);
        check("t3_done", obs_done, 3);

        // 3b: latch and pulse rising together: pulse is dropped.
        set_buttons(12'h0F0);
        tick(HP);
        latch_pulse();
        run_pulses(3, seq);
        set_latch(1'b1);
        set_pulse(1'b1);
        tick(HP);
        set_pulse(1'b0);
        tick(HP);
        set_latch(1'b0);
        tick(HP);
        run_pulses(FB, seq);
        check("t3b_seq", seq, 16'hF0FF);
        check("t3b_poll", poll_count, 4);

        // 4: stalled frame times out; pulses in idle ignored.
        set_buttons(12'hFFF);
        tick(HP);
        latch_pulse();
        run_pulses(3, seq);
        check("t4_mid", bus.snes_data, 0);
        tick(TO + 50);
        check("t4_idle", bus.snes_data, 1);
        check("t4_poll", poll_count, 4);
        run_pulses(2, seq);
        check("t4_extra_pulse", seq, 16'hFFFF);
        check("t4_done", obs_done, 4);

        // 5: disabled pad looks unplugged; disable mid-frame aborts.
        set_enable(1'b0);
        tick(HP);
        do_frame(12'hFFF, seq);
        check("t5_off_seq", seq, 16'hFFFF);
        check("t5_off_done", obs_done, 4);
        set_enable(1'b1);
        tick(HP);
        latch_pulse();
        run_pulses(4, seq);
        check("t5_mid", bus.snes_data, 0);
        set_enable(1'b0);
        tick(3);
        check("t5_abort", bus.snes_data, 1);
        set_enable(1'b1);
        tick(HP);
        run_pulses(2, seq);
        check("t5_after_seq", seq, 16'hFFFF);
        check("t5_poll", poll_count, 4);

        // 6: poll counter wraps after 256 frames.
        rst_n = 1'b0;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        mask = 2;
        tick(HP);
        base = obs_done;
        for (int i = 0; i < 256; i++) begin
            do_frame(12'(i * 37 + 5), seq);
            if (i == 254) check("t6_poll_255", poll_count, 255);
        end
        check("t6_wrap", poll_count, 0);
        check("t6_frames", obs_done - base, 256);

        // 6b: asynchronous reset mid-frame.
        set_buttons(12'h801);
        tick(HP);
        latch_pulse();
        check("t6_pre_reset", bus.snes_data, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_data", bus.snes_data, 1);
        check("t6_async_done", frame_done, 0);
        bus.snes_latch = 1'b0;
        bus.snes_pulse = 1'b0;
        tick(2);
        rst_n = 1'b1;
        mask = 2;
        tick(HP);
        do_frame(12'h801, seq);
        check("t6_post_seq", seq, 16'h7FEF);
        check("t6_post_poll", poll_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
